// File: rtl/tdc_pkg.sv
// Shared TDC definitions: event word layout used by the channel, packer and timestamp decoder.
// No logic; constants, the event struct and a field-unpack helper.
// No flow control here; consumers apply their own.
package tdc_pkg;

  localparam int DATA_WIDTH   = 64;
  localparam int COARSE_WIDTH = 56;
  localparam int FINE_WIDTH   = 8;

  // Fine interpolation code in the low byte, coarse counter above it.
  localparam int FINE_LSB   = 0;
  localparam int FINE_MSB   = FINE_LSB + FINE_WIDTH - 1;
  localparam int COARSE_LSB = FINE_MSB + 1;
  localparam int COARSE_MSB = COARSE_LSB + COARSE_WIDTH - 1;

  typedef struct packed {
    logic [COARSE_WIDTH-1:0] coarse;
    logic [FINE_WIDTH-1:0]   fine;
  } tdc_event_t;

  function automatic tdc_event_t tdc_unpack(input logic [DATA_WIDTH-1:0] w);
    return tdc_event_t'(w);
  endfunction

endpackage

// File: rtl/tdc_axis_packer_if.sv
// AXI4-Stream bundle carrying TDC event words from the packer to the DMA path.
// Wires only, no latency.
// Standard valid/ready: master holds tdata/tlast stable while tvalid is high and tready low.
interface tdc_axis_packer_if import tdc_pkg::*;;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tdc_skid_fifo4.sv
// 4-entry register FIFO holding event words between the channel FIFO and the stream port.
// Head is combinational from storage; push visible at head the cycle after it is written.
// Push and pop in the same cycle are both honoured; a push into a full FIFO without a pop is dropped.
// Ports: clk/clr, push/push_dat write side, pop read side, head = oldest entry, occ = entries held.
module tdc_skid_fifo4 import tdc_pkg::*; #(
  parameter int W = DATA_WIDTH
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [2:0]   occ
);

  logic [W-1:0] mem [4];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = pop & (occ != 3'd0);
  assign push_ok = push & ((occ != 3'd4) | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clr) begin
      // Storage is cleared too so the stream data reads zero out of reset.
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 3'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 2'd1;
      occ <= occ + {2'b00, push_ok} - {2'b00, pop_ok};
    end
  end

endmodule

// File: rtl/tdc_axis_packer.sv
// Drains the channel event FIFO into AXI4-Stream packets closed by length or by idle timeout.
// First fifo_rd_en to first tvalid is 3 cycles; one word per cycle sustained while tready is high.
// tready low stalls FIFO reads once 3 words are held or in flight; nothing is dropped.
// Ports: clk/clr, en, channel FIFO read side (fifo_empty/fifo_rd_en/fifo_dout),
//        m_axis stream master, word_count/pkt_count accepted-beat counters, busy.
module tdc_axis_packer #(
  parameter int DATA_WIDTH     = tdc_pkg::DATA_WIDTH,
  parameter int BURST_LEN      = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  tdc_axis_packer_if.master     m_axis,
  output logic [31:0]           word_count,
  output logic [31:0]           pkt_count,
  output logic                  busy
);

  localparam int BW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]            occ;
  logic [2:0]            occ_inf;
  logic [DATA_WIDTH-1:0] head;
  logic                  inflight;
  logic                  flush;
  logic [BW-1:0]         beat;
  logic [IW-1:0]         idle_cnt;
  logic                  last_beat;
  logic                  flush_last;
  logic                  idle;
  logic                  tvalid;
  logic                  tlast;
  logic                  hs;

  tdc_skid_fifo4 #(.W(DATA_WIDTH)) u_buf (
    .clk      (clk),
    .clr      (clr),
    .push     (inflight),
    .push_dat (fifo_dout),
    .pop      (hs),
    .head     (head),
    .occ      (occ)
  );

  assign last_beat  = (beat == BW'(BURST_LEN - 1));
  // The single held word closes the packet only when nothing else is on its way.
  assign flush_last = flush & (occ == 3'd1) & ~inflight;
  assign idle       = (occ == 3'd1) & ~inflight & fifo_empty;

  // One word is always held back so it can carry tlast if the stream goes quiet.
  assign tvalid = (occ >= 3'd2) | ((occ != 3'd0) & (last_beat | flush));
  assign tlast  = tvalid & (last_beat | flush_last);
  assign hs     = tvalid & m_axis.tready;

  assign m_axis.tdata  = head;
  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = tlast;

  // Read while at most 2 words are held or in flight; at 3, read only when a beat
  // leaves this cycle, so the total never exceeds 3 and a steady 2-held/1-in-flight
  // pipeline runs at full rate. Reads pause while a flush-closed tlast is on the bus,
  // otherwise a new word would arrive and retract that tlast before the handshake.
  assign occ_inf    = occ + {2'b00, inflight};
  assign fifo_rd_en = ~clr & en & ~fifo_empty & ~flush_last &
                      ((occ_inf <= 3'd2) | ((occ_inf == 3'd3) & hs));

  assign busy = (occ != 3'd0) | inflight;

  always_ff @(posedge clk) begin
    if (clr) begin
      inflight   <= 1'b0;
      flush      <= 1'b0;
      beat       <= '0;
      idle_cnt   <= '0;
      word_count <= 32'd0;
      pkt_count  <= 32'd0;
    end else begin
      inflight <= fifo_rd_en;

      if (hs) begin
        word_count <= word_count + 32'd1;
        if (tlast) begin
          beat      <= '0;
          pkt_count <= pkt_count + 32'd1;
        end else begin
          beat <= beat + BW'(1);
        end
      end

      if (idle) begin
        if (idle_cnt != IW'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + IW'(1);
      end else begin
        idle_cnt <= '0;
      end

      // A captured word means the held one is no longer the last, so the
      // pending flush is withdrawn; disable re-arms it once nothing is in flight.
      if ((hs & tlast) | inflight)
        flush <= 1'b0;
      else if ((~en & ~inflight) | (idle & (idle_cnt == IW'(TIMEOUT_CYCLES - 1))))
        flush <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdc_axis_packer.sv
module tb_tdc_axis_packer;
  import tdc_pkg::*;

  localparam int BURST = 256;
  localparam int TMO   = 1024;

  typedef enum int {K_STREAM, K_SINGLE, K_RANDOM, K_DROP} kind_t;
  typedef struct {
    kind_t kind;
    int    n;
    int    rdy;
    int    exp_wc;
    int    exp_pc;
  } vec_t;
  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;

  logic        clk;
  logic        clr;
  logic        en;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [63:0] fifo_dout;
  logic [31:0] word_count;
  logic [31:0] pkt_count;
  logic        busy;

  tdc_axis_packer_if axis ();

  tdc_axis_packer #(.DATA_WIDTH(64), .BURST_LEN(BURST), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .m_axis     (axis),
    .word_count (word_count),
    .pkt_count  (pkt_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] src_q [$];
  beat_t       exp_q [$];
  int          n_cmp, n_bad, cyc, ready_pct;
  logic        rd_s, vld_s, last_s, prev_stall, prev_last;
  logic [63:0] dat_s, prev_dat;

  // Packet boundaries: every BURST-th beat, plus the final word of a burst of traffic.
  function automatic logic exp_last(input int i, input int n);
    return ((i + 1) % BURST == 0) || (i == n - 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, score handshakes, then model the channel FIFO
  // (standard mode: data appears the cycle after the read strobe).
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    cyc++;
    rd_s   = fifo_rd_en;
    vld_s  = axis.tvalid;
    last_s = axis.tlast;
    dat_s  = axis.tdata;
    if (prev_stall) begin
      check("stall_tvalid", vld_s, 1);
      check("stall_tdata", dat_s, prev_dat);
      check("stall_tlast", last_s, prev_last);
    end
    if (vld_s && axis.tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_beat: got 0x%0h want no beat", dat_s);
      end else begin
        e = exp_q.pop_front();
        check("tdata", dat_s, e.d);
        check("tlast", last_s, e.l);
      end
    end
    prev_stall = vld_s && !axis.tready;
    prev_dat   = dat_s;
    prev_last  = last_s;
    @(posedge clk);
    #1;
    if (rd_s && src_q.size() > 0) fifo_dout = src_q.pop_front();
    fifo_empty  = (src_q.size() == 0);
    axis.tready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic do_reset(input logic keep_src);
    clr         = 1'b1;
    en          = 1'b0;
    axis.tready = 1'b0;
    prev_stall  = 1'b0;
    exp_q.delete();
    if (!keep_src) src_q.delete();
    fifo_empty = (src_q.size() == 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_fifo_rd_en", fifo_rd_en, 0);
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tlast", axis.tlast, 0);
    check("rst_tdata", axis.tdata, 0);
    check("rst_word_count", word_count, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic load(input int n, input logic fixed);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = fixed ? 64'h0000_0000_0000_12AB : {$urandom, $urandom};
      src_q.push_back(w);
      exp_q.push_back('{d: w, l: exp_last(i, n)});
    end
    fifo_empty = (src_q.size() == 0);
  endtask

  vec_t tbl [4];

  initial begin
    int k, t0, tv, gaps, last_rd, n2;
    logic [63:0] w;
    clr = 1'b1; en = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
    axis.tready = 1'b0; ready_pct = 100;
    n_cmp = 0; n_bad = 0; cyc = 0; prev_stall = 1'b0; prev_dat = '0; prev_last = 1'b0;

    tbl[0] = '{kind: K_STREAM, n: 600, rdy: 100, exp_wc: 600, exp_pc: 3};
    tbl[1] = '{kind: K_SINGLE, n: 1,   rdy: 100, exp_wc: 1,   exp_pc: 1};
    tbl[2] = '{kind: K_RANDOM, n: 300, rdy: 50,  exp_wc: 300, exp_pc: 2};
    tbl[3] = '{kind: K_DROP,   n: 10,  rdy: 100, exp_wc: 10,  exp_pc: 1};

    for (int c = 0; c < 4; c++) begin
      do_reset(1'b0);
      ready_pct   = tbl[c].rdy;
      axis.tready = ($urandom_range(99) < ready_pct);
      load(tbl[c].n, tbl[c].kind == K_SINGLE);
      en = 1'b1;
      t0 = -1; tv = -1; gaps = 0; last_rd = -1;
      for (k = 0; k < 6000; k++) begin
        cycle();
        if (!en) check("rd_en_while_disabled", rd_s, 0);
        if (rd_s) begin
          if (t0 < 0) t0 = cyc;
          else if (cyc != last_rd + 1) gaps++;
          last_rd = cyc;
        end
        if (vld_s && tv < 0) tv = cyc;
        if (tbl[c].kind == K_DROP && en && src_q.size() == 0) begin
          en = 1'b0;
          // Words arriving after disable must stay in the channel FIFO.
          for (int i = 0; i < 3; i++) src_q.push_back({$urandom, $urandom});
          fifo_empty = 1'b0;
        end
        if (exp_q.size() == 0) break;
      end
      check("drain_done", exp_q.size(), 0);
      check("word_count", word_count, tbl[c].exp_wc);
      check("pkt_count", pkt_count, tbl[c].exp_pc);
      check("busy_after", busy, 0);
      case (tbl[c].kind)
        K_STREAM: begin
          check("first_tvalid_latency", tv - t0, 3);
          check("rd_en_gaps", gaps, 0);
        end
        K_SINGLE: check("timeout_latency", tv - t0, TMO + 2);
        K_DROP:   check("drop_no_timeout", k < 64, 1);
        default: ;
      endcase
    end

    // A second word arriving on the last idle cycle before timeout keeps the packet open.
    do_reset(1'b0);
    ready_pct = 100; axis.tready = 1'b1;
    w = {$urandom, $urandom};
    src_q.push_back(w);
    exp_q.push_back('{d: w, l: 1'b0});
    fifo_empty = 1'b0; en = 1'b1; t0 = -1;
    for (k = 0; k < 20 && t0 < 0; k++) begin
      cycle();
      if (rd_s) t0 = cyc;
    end
    check("idle_first_read", t0 >= 0, 1);
    for (k = 0; k < 2000 && cyc < t0 + TMO; k++) cycle();
    w = {$urandom, $urandom};
    src_q.push_back(w);
    exp_q.push_back('{d: w, l: 1'b1});
    fifo_empty = 1'b0;
    cycle();
    check("late_word_no_tvalid_a", vld_s, 0);
    cycle();
    check("late_word_no_flush", vld_s, 0);
    for (k = 0; k < 3000 && exp_q.size() > 0; k++) cycle();
    check("late_drain_done", exp_q.size(), 0);
    check("late_word_count", word_count, 2);
    check("late_pkt_count", pkt_count, 1);

    // clr mid-packet: held and in-flight words are lost, counting restarts at beat 0.
    do_reset(1'b0);
    ready_pct = 100; axis.tready = 1'b1;
    load(500, 1'b0);
    en = 1'b1;
    for (k = 0; k < 2000 && word_count < 100; k++) cycle();
    check("mid_word_count", word_count, 100);
    do_reset(1'b1);
    n2 = src_q.size();
    for (int i = 0; i < n2; i++) exp_q.push_back('{d: src_q[i], l: exp_last(i, n2)});
    en = 1'b1; axis.tready = 1'b1;
    for (k = 0; k < 4000 && exp_q.size() > 0; k++) cycle();
    check("post_clr_drain_done", exp_q.size(), 0);
    check("post_clr_word_count", word_count, n2);
    check("post_clr_pkt_count", pkt_count, (n2 + BURST - 1) / BURST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
